i2s_playback_tx: RTL and testbench
==================================

Name: i2s_playback_tx

Overview:
- Parametrised I2S/TDM playback transmitter with an internal frame FIFO.
- Sits between the sampler voice mixer and the codec pins ac_bclk, ac_pblrc and ac_pbdat.
- Generates the bit clock and LR/frame clock from board_clk, serialises NUM_CHANNELS slots per frame, and supports I2S or left-justified alignment.
- On FIFO underrun it transmits silence and counts the event.

Parameters:
- DATA_WIDTH, 24: sample bits per channel, MSB first.
- SLOT_WIDTH, 32: bit clocks per channel slot; DATA_WIDTH <= SLOT_WIDTH.
- NUM_CHANNELS, 2: slots per frame; even, 2..8.
- BCLK_DIV, 4: board_clk cycles per bclk half-period; >= 2.
- FIFO_DEPTH, 8: frame FIFO entries; power of two, >= 2.
- LEFT_JUSTIFIED, 0: 0 = I2S (one-bclk data delay), 1 = left-justified.

Ports:
- board_clk  in  1  system clock; all logic is on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  transmitter run request.
- s_data  in  DATA_WIDTH*NUM_CHANNELS  one frame; channel 0 in the LSBs.
- s_valid  in  1  frame valid.
- s_ready  out  1  FIFO can accept a frame.
- ac_bclk  out  1  bit clock.
- ac_pblrc  out  1  LR/frame clock.
- ac_pbdat  out  1  serial data.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  frames currently stored.
- underrun  out  1  sticky flag; cleared when enable rises.
- underrun_cnt  out  16  underrun count, saturating at 0xFFFF.

Behaviour:
- Reset asserted (low), immediately:
  - ac_bclk=0, ac_pblrc=0, ac_pbdat=0, s_ready=0.
  - FIFO emptied, fifo_level=0, underrun=0, underrun_cnt=0.
  - State = IDLE.
- s_ready after reset: rises on the first board_clk edge after reset deasserts.
- FIFO push: write on s_valid && s_ready.
- s_ready = (fifo_level < FIFO_DEPTH); independent of enable.
- Simultaneous push and pop: fifo_level unchanged. A push to a full FIFO is impossible because s_ready=0.
- FRAME_BITS = SLOT_WIDTH*NUM_CHANNELS. Bit index b runs 0..FRAME_BITS-1.
- Bclk divider: counter 0..BCLK_DIV-1; ac_bclk toggles when it wraps, so the bclk period is 2*BCLK_DIV board_clk cycles.
- ac_pbdat and ac_pblrc change only on the board_clk edge that drives ac_bclk 1->0. The codec samples them on the rising bclk edge.
- Data content at bit b:
  - Slot s = b/SLOT_WIDTH, position p = b mod SLOT_WIDTH.
  - ac_pbdat = channel s bit (DATA_WIDTH-1-p) when p < DATA_WIDTH, else 0.
- LR/frame clock:
  - LEFT_JUSTIFIED=1: ac_pblrc = (b >= FRAME_BITS/2).
  - LEFT_JUSTIFIED=0: ac_pblrc = (((b+1) mod FRAME_BITS) >= FRAME_BITS/2), i.e. pblrc leads data by one bclk.
- States:
  - IDLE: ac_bclk held 0, divider cleared. enable=1 -> START.
  - START: clears underrun and underrun_cnt. Next falling-bclk slot is b=0 -> RUN.
  - RUN:
    - At each b=0 falling edge, pop the FIFO head into the shift register.
    - If the FIFO is empty there, load zeros, set underrun=1 and increment underrun_cnt (saturating).
    - At b=FRAME_BITS-1 with enable=0 -> STOP.
  - STOP: completes the final rising bclk half, then IDLE with ac_bclk=0 and ac_pbdat=0. ac_pblrc holds its last value.
- enable deasserted mid-frame: the current frame completes in full; no truncation.
- Latency: a frame pushed into an empty FIFO while in RUN goes out at the next b=0 boundary. A push on the same board_clk as that boundary's pop is not seen until the following frame.
- Reset mid-frame: outputs clear immediately; the partial frame is lost.

Test Plan:
- Basic I2S, parameters DATA_WIDTH=16, SLOT_WIDTH=16, NUM_CHANNELS=2, BCLK_DIV=2, LEFT_JUSTIFIED=0:
  - Stimulus: push frame {0x8001, 0xA5A5} (ch1, ch0), then enable=1.
  - Response: bclk period is 4 clocks. ch0 bits 1010010110100101 appear on b=0..15 and ch1 1000000000000001 on b=16..31. pblrc rises at the falling edge of b=15.
- Left-justified, same frame with LEFT_JUSTIFIED=1: pblrc rises coincident with b=16; data identical.
- Padding and TDM, DATA_WIDTH=24, SLOT_WIDTH=32, NUM_CHANNELS=4, ch2=0xFFFFFF:
  - Slot 2 shows 24 ones then 8 zeros.
  - pblrc is high for b=63..126 (I2S) and low at b=127.
- Underrun: enable with an empty FIFO for 3 frames:
  - pbdat stays 0; underrun=1, underrun_cnt=3.
  - Push one frame: it transmits next frame; count stays 3.
- Back-pressure and stop:
  - Push 8 frames with enable=0: fifo_level=8, s_ready=0, a 9th s_valid is ignored.
  - Enable, then drop enable at b=5: the frame finishes to b=31, bclk stops low, fifo_level=7.
- Async reset at b=10 in RUN: all outputs are 0 within the same cycle; after release, s_ready=1, fifo_level=0, underrun_cnt=0.

Source files
------------

// File: rtl/i2s_playback_tx.sv
// i2s_playback_tx: I2S / left-justified TDM playback transmitter with an internal frame FIFO
// Ports:
//    board_clk, reset      system clock (rising edge), asynchronous active-low reset
//    enable                transmitter run request
//    s_data/s_valid/s_ready one frame per push, channel 0 in the LSBs
//    ac_bclk/ac_pblrc/ac_pbdat codec bit clock, LR/frame clock and serial data
//    fifo_level            frames currently stored
//    underrun/underrun_cnt sticky underrun flag and saturating underrun count
module i2s_playback_tx #(
   parameter int DATA_WIDTH     = 24,
   parameter int SLOT_WIDTH     = 32,
   parameter int NUM_CHANNELS   = 2,
   parameter int BCLK_DIV       = 4,
   parameter int FIFO_DEPTH     = 8,
   parameter int LEFT_JUSTIFIED = 0
) (
   input  logic                                 board_clk,
   input  logic                                 reset,
   input  logic                                 enable,
   input  logic [DATA_WIDTH*NUM_CHANNELS-1:0]   s_data,
   input  logic                                 s_valid,
   output logic                                 s_ready,
   output logic                                 ac_bclk,
   output logic                                 ac_pblrc,
   output logic                                 ac_pbdat,
   output logic [$clog2(FIFO_DEPTH):0]          fifo_level,
   output logic                                 underrun,
   output logic [15:0]                          underrun_cnt
);
   localparam int FW = DATA_WIDTH * NUM_CHANNELS;
   localparam int FB = SLOT_WIDTH * NUM_CHANNELS;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam int BW = $clog2(FB);
   localparam int VW = $clog2(BCLK_DIV);
   typedef enum logic [1:0] {S_IDLE, S_START, S_RUN, S_STOP} state_t;
   state_t r_state, w_next;
   logic [VW-1:0] r_div;
   logic r_bclk, r_lrc, r_dat, r_ready, r_unr;
   logic [15:0] r_cnt;
   logic [LW-1:0] r_level, w_level;
   logic [AW-1:0] r_wp, r_rp;
   logic [FW-1:0] r_mem [FIFO_DEPTH];
   logic [FW-1:0] r_frame, w_frame;
   logic [BW-1:0] r_bit, w_nb;
   logic w_wrap, w_fall, w_load, w_pop, w_push, w_lrc, w_dat;
   int w_slot, w_pos;
   assign w_wrap  = r_div == VW'(BCLK_DIV - 1);
   // a falling bclk edge is the only point where data and pblrc advance
   assign w_fall  = (r_state != S_IDLE) && w_wrap && r_bclk;
   assign w_nb    = (r_state == S_START || r_bit == BW'(FB - 1)) ? '0 : r_bit + 1'b1;
   assign w_load  = w_fall && (r_state == S_START || r_state == S_RUN) && w_nb == '0;
   assign w_pop   = w_load && r_level != '0;
   assign w_push  = s_valid && r_ready;
   assign w_level = r_level + LW'(w_push) - LW'(w_pop);
   // an empty FIFO at the frame boundary plays a silent frame
   assign w_frame = w_load ? (w_pop ? r_mem[r_rp] : '0) : r_frame;
   always_comb begin
      w_slot = int'(w_nb) / SLOT_WIDTH;
      w_pos  = int'(w_nb) % SLOT_WIDTH;
      w_dat  = (w_pos < DATA_WIDTH) &&
               |(w_frame & (FW'(1) << (w_slot * DATA_WIDTH + DATA_WIDTH - 1 - w_pos)));
      // I2S drives pblrc one bclk ahead of the slot it announces
      w_lrc  = (LEFT_JUSTIFIED != 0) ? (int'(w_nb) >= FB / 2)
                                     : (((int'(w_nb) + 1) % FB) >= FB / 2);
   end
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (enable) w_next = S_START;
         S_START: if (w_fall) w_next = S_RUN;
         S_RUN:   if (w_fall && w_nb == BW'(FB - 1) && !enable) w_next = S_STOP;
         S_STOP:  if (w_fall) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end
   always_ff @(posedge board_clk or negedge reset)
      if (!reset) r_state <= S_IDLE;
      else r_state <= w_next;
   always_ff @(posedge board_clk)
      if (w_push) r_mem[r_wp] <= s_data;
   always_ff @(posedge board_clk or negedge reset)
      if (!reset) begin
         r_div   <= '0;
         r_bclk  <= 1'b0;
         r_lrc   <= 1'b0;
         r_dat   <= 1'b0;
         r_ready <= 1'b0;
         r_unr   <= 1'b0;
         r_cnt   <= '0;
         r_level <= '0;
         r_wp    <= '0;
         r_rp    <= '0;
         r_frame <= '0;
         r_bit   <= '0;
      end else begin
         r_ready <= w_level < LW'(FIFO_DEPTH);
         r_level <= w_level;
         if (w_push) r_wp <= r_wp + 1'b1;
         if (w_pop) r_rp <= r_rp + 1'b1;
         r_div  <= (r_state == S_IDLE || w_wrap) ? '0 : r_div + 1'b1;
         r_bclk <= (r_state == S_IDLE) ? 1'b0 : r_bclk ^ w_wrap;
         if (w_fall) begin
            r_dat <= (r_state == S_STOP) ? 1'b0 : w_dat;
            if (r_state != S_STOP) begin
               r_lrc   <= w_lrc;
               r_bit   <= w_nb;
               r_frame <= w_frame;
            end
         end
         if (r_state == S_START) begin
            r_unr <= 1'b0;
            r_cnt <= '0;
         end
         if (w_load && !w_pop) begin
            r_unr <= 1'b1;
            r_cnt <= (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
         end
      end
   assign s_ready      = r_ready;
   assign ac_bclk      = r_bclk;
   assign ac_pblrc     = r_lrc;
   assign ac_pbdat     = r_dat;
   assign fifo_level   = r_level;
   assign underrun     = r_unr;
   assign underrun_cnt = r_cnt;
endmodule

// File: tb/tb_i2s_playback_tx.sv
// tb_i2s_playback_tx: directed/random bench for i2s_playback_tx against a bit-stream model
module tb_i2s_playback_tx;
   logic board_clk = 1'b0;
   logic reset = 1'b1;
   always #5 board_clk = ~board_clk;

   // A: I2S 16/16/2, B: left-justified copy fed identically, C: 24/32 four-slot TDM
   logic en_ab = 1'b0, v_ab = 1'b0;
   logic [31:0] d_ab = '0;
   logic a_rdy, a_bclk, a_lrc, a_dat, a_unr, b_rdy, b_bclk, b_lrc, b_dat, b_unr;
   logic [3:0] a_lvl, b_lvl;
   logic [15:0] a_cnt, b_cnt;
   logic en_c = 1'b0, v_c = 1'b0;
   logic [95:0] d_c = '0;
   logic c_rdy, c_bclk, c_lrc, c_dat, c_unr;
   logic [2:0] c_lvl;
   logic [15:0] c_cnt;

   i2s_playback_tx #(.DATA_WIDTH(16), .SLOT_WIDTH(16), .NUM_CHANNELS(2), .BCLK_DIV(2),
      .FIFO_DEPTH(8), .LEFT_JUSTIFIED(0)) u_a (.board_clk(board_clk), .reset(reset),
      .enable(en_ab), .s_data(d_ab), .s_valid(v_ab), .s_ready(a_rdy), .ac_bclk(a_bclk),
      .ac_pblrc(a_lrc), .ac_pbdat(a_dat), .fifo_level(a_lvl), .underrun(a_unr), .underrun_cnt(a_cnt));
   i2s_playback_tx #(.DATA_WIDTH(16), .SLOT_WIDTH(16), .NUM_CHANNELS(2), .BCLK_DIV(2),
      .FIFO_DEPTH(8), .LEFT_JUSTIFIED(1)) u_b (.board_clk(board_clk), .reset(reset),
      .enable(en_ab), .s_data(d_ab), .s_valid(v_ab), .s_ready(b_rdy), .ac_bclk(b_bclk),
      .ac_pblrc(b_lrc), .ac_pbdat(b_dat), .fifo_level(b_lvl), .underrun(b_unr), .underrun_cnt(b_cnt));
   i2s_playback_tx #(.DATA_WIDTH(24), .SLOT_WIDTH(32), .NUM_CHANNELS(4), .BCLK_DIV(2),
      .FIFO_DEPTH(4), .LEFT_JUSTIFIED(0)) u_c (.board_clk(board_clk), .reset(reset),
      .enable(en_c), .s_data(d_c), .s_valid(v_c), .s_ready(c_rdy), .ac_bclk(c_bclk),
      .ac_pblrc(c_lrc), .ac_pbdat(c_dat), .fifo_level(c_lvl), .underrun(c_unr), .underrun_cnt(c_cnt));

   int checks = 0, errors = 0, cyc = 0;
   logic [1:0] cap_a[$], cap_b[$], cap_c[$], exp_a[$], exp_b[$], exp_c[$];
   int stamp_a[$];
   logic [2:0] pa, pb, pc;
   logic prst;
   logic [31:0] fq[8];
   logic [31:0] fr;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // codec view: {pbdat, pblrc} sampled at every rising bclk
   initial begin
      pa = '0; pb = '0; pc = '0; prst = 1'b0;
      forever begin
         @(negedge board_clk);
         cyc++;
         if (a_bclk && !pa[0]) begin
            cap_a.push_back({a_dat, a_lrc});
            stamp_a.push_back(cyc);
         end
         if (b_bclk && !pb[0]) cap_b.push_back({b_dat, b_lrc});
         if (c_bclk && !pc[0]) cap_c.push_back({c_dat, c_lrc});
         if (reset && prst) begin
            if ({a_dat, a_lrc} != pa[2:1]) chk("edge_a", 32'(pa[0] && !a_bclk), 1);
            if ({b_dat, b_lrc} != pb[2:1]) chk("edge_b", 32'(pb[0] && !b_bclk), 1);
            if ({c_dat, c_lrc} != pc[2:1]) chk("edge_c", 32'(pc[0] && !c_bclk), 1);
         end
         pa = {a_dat, a_lrc, a_bclk};
         pb = {b_dat, b_lrc, b_bclk};
         pc = {c_dat, c_lrc, c_bclk};
         prst = reset;
      end
   end

   function automatic int capn(input int w);
      return (w == 0) ? cap_a.size() : (w == 1) ? cap_b.size() : cap_c.size();
   endfunction
   function automatic logic [1:0] capv(input int w, input int k);
      return (w == 0) ? cap_a[k] : (w == 1) ? cap_b[k] : cap_c[k];
   endfunction
   function automatic int expn(input int w);
      return (w == 0) ? exp_a.size() : (w == 1) ? exp_b.size() : exp_c.size();
   endfunction
   function automatic logic [1:0] expv(input int w, input int k);
      return (w == 0) ? exp_a[k] : (w == 1) ? exp_b[k] : exp_c[k];
   endfunction

   // expected codec stream for one frame: slots in channel order, MSB first, zero padded
   function automatic void model(input int w, input logic [95:0] f);
      int dw, sw, nc, fb, b;
      logic [95:0] ch;
      logic d, l;
      dw = (w == 2) ? 24 : 16;
      sw = (w == 2) ? 32 : 16;
      nc = (w == 2) ? 4 : 2;
      fb = sw * nc;
      for (int s = 0; s < nc; s++) begin
         ch = (f >> (s * dw)) & ((96'd1 << dw) - 96'd1);
         for (int p = 0; p < sw; p++) begin
            b = s * sw + p;
            d = (p < dw) && |((ch >> (dw - 1 - p)) & 96'd1);
            l = (w == 1) ? (b >= fb / 2) : (b >= fb / 2 - 1 && b < fb - 1);
            if (w == 0) exp_a.push_back({d, l});
            else if (w == 1) exp_b.push_back({d, l});
            else exp_c.push_back({d, l});
         end
      end
   endfunction

   function automatic void clear();
      cap_a.delete(); cap_b.delete(); cap_c.delete(); stamp_a.delete();
      exp_a.delete(); exp_b.delete(); exp_c.delete();
   endfunction

   task automatic cmp_stream(input int w, input string tag);
      logic [1:0] v;
      chk({tag, "_nrises"}, capn(w), expn(w) + 1);
      if (capn(w) > 0) begin
         v = capv(w, 0);
         chk({tag, "_pre_dat"}, 32'(v[1]), 0);
      end
      for (int k = 0; k < expn(w) && k + 1 < capn(w); k++)
         chk($sformatf("%s_b%0d", tag, k), 32'(capv(w, k + 1)), 32'(expv(w, k)));
   endtask

   task automatic wait_rises(input int w, input int n);
      for (int k = 0; k < 5000 && capn(w) < n; k++) @(negedge board_clk);
      chk("wait_rises", 32'(capn(w) >= n), 1);
   endtask

   task automatic wait_idle(input int w);
      int lo;
      lo = 0;
      for (int k = 0; k < 5000 && lo < 8; k++) begin
         @(negedge board_clk);
         lo = ((w == 2) ? c_bclk : a_bclk) ? 0 : lo + 1;
      end
      chk("wait_idle", 32'(lo >= 8), 1);
   endtask

   task automatic push_ab(input logic [31:0] d);
      @(negedge board_clk);
      v_ab = 1'b1;
      d_ab = d;
      @(negedge board_clk);
      v_ab = 1'b0;
   endtask

   task automatic ab_both(input logic [31:0] f);
      model(0, {64'd0, f});
      model(1, {64'd0, f});
   endtask

   initial begin
      #1 reset = 1'b0;
      repeat (3) @(negedge board_clk);
      chk("rst_a", {a_bclk, a_lrc, a_dat, a_rdy, a_unr, a_lvl, a_cnt}, 0);
      chk("rst_c", {c_bclk, c_lrc, c_dat, c_rdy, c_unr, c_lvl, c_cnt}, 0);
      reset = 1'b1;
      @(negedge board_clk);
      chk("rdy_after_rst", {a_rdy, a_lvl}, {1'b1, 4'd0});

      // basic frame, I2S on A and left-justified on B
      clear();
      push_ab(32'h8001_A5A5);
      chk("lvl_one", a_lvl, 1);
      ab_both(32'h8001_A5A5);
      en_ab = 1'b1;
      wait_rises(0, 7);
      en_ab = 1'b0;
      wait_idle(0);
      cmp_stream(0, "i2s");
      cmp_stream(1, "lj");
      if (stamp_a.size() > 2) chk("bclk_period", stamp_a[2] - stamp_a[1], 4);
      if (cap_a.size() > 17) begin
         chk("i2s_lrc_b14", 32'(cap_a[15][0]), 0);
         chk("i2s_lrc_b15", 32'(cap_a[16][0]), 1);
      end
      if (cap_b.size() > 17) begin
         chk("lj_lrc_b15", 32'(cap_b[16][0]), 0);
         chk("lj_lrc_b16", 32'(cap_b[17][0]), 1);
      end
      chk("basic_end", {a_bclk, a_dat, a_unr, a_lvl, a_cnt}, 0);

      // three random frames back to back
      clear();
      for (int i = 0; i < 3; i++) begin
         fr = $urandom;
         push_ab(fr);
         ab_both(fr);
      end
      en_ab = 1'b1;
      wait_rises(0, 1 + 64 + 5);
      en_ab = 1'b0;
      wait_idle(0);
      cmp_stream(0, "rnd_i2s");
      cmp_stream(1, "rnd_lj");
      chk("rnd_end", {a_lvl, a_unr, b_lvl, b_unr}, 0);

      // underrun: three silent frames, then a late push plays in the fourth
      clear();
      en_ab = 1'b1;
      for (int i = 0; i < 3; i++) ab_both(32'd0);
      wait_rises(0, 1 + 64 + 8);
      fr = $urandom;
      push_ab(fr);
      ab_both(fr);
      wait_rises(0, 1 + 96 + 5);
      en_ab = 1'b0;
      wait_idle(0);
      cmp_stream(0, "unr_i2s");
      cmp_stream(1, "unr_lj");
      chk("unr_flag", a_unr, 1);
      chk("unr_cnt", a_cnt, 3);
      chk("unr_lvl", a_lvl, 0);

      // back-pressure: fill, refused ninth push, then a single-frame run
      clear();
      @(negedge board_clk);
      v_ab = 1'b1;
      for (int i = 0; i < 8; i++) begin
         fq[i] = $urandom;
         d_ab = fq[i];
         @(negedge board_clk);
      end
      d_ab = $urandom;
      @(negedge board_clk);
      v_ab = 1'b0;
      chk("full_lvl", a_lvl, 8);
      chk("full_rdy", a_rdy, 0);
      en_ab = 1'b1;
      repeat (3) @(negedge board_clk);
      chk("start_clr", {a_unr, a_cnt}, 0);
      ab_both(fq[0]);
      wait_rises(0, 1 + 6);
      en_ab = 1'b0;
      wait_idle(0);
      cmp_stream(0, "bp_i2s");
      cmp_stream(1, "bp_lj");
      chk("bp_lvl", a_lvl, 7);
      chk("bp_rdy", a_rdy, 1);
      chk("bp_stop", {a_bclk, a_dat}, 0);

      // FIFO order across two further frames
      clear();
      ab_both(fq[1]);
      ab_both(fq[2]);
      en_ab = 1'b1;
      wait_rises(0, 1 + 32 + 5);
      en_ab = 1'b0;
      wait_idle(0);
      cmp_stream(0, "ord_i2s");
      cmp_stream(1, "ord_lj");
      chk("ord_lvl", a_lvl, 5);

      // asynchronous reset in the middle of a frame
      clear();
      en_ab = 1'b1;
      wait_rises(0, 1 + 11);
      reset = 1'b0;
      #1;
      chk("async_rst_a", {a_bclk, a_lrc, a_dat, a_rdy, a_unr, a_lvl, a_cnt}, 0);
      chk("async_rst_b", {b_bclk, b_lrc, b_dat, b_rdy, b_lvl}, 0);
      @(negedge board_clk);
      reset = 1'b1;
      en_ab = 1'b0;
      @(negedge board_clk);
      chk("post_rst", {a_rdy, a_lvl, a_cnt}, {1'b1, 4'd0, 16'd0});

      // four-slot TDM with padding
      clear();
      d_c = {24'($urandom), 24'hFFFFFF, 24'($urandom), 24'($urandom)};
      model(2, d_c);
      @(negedge board_clk);
      v_c = 1'b1;
      @(negedge board_clk);
      v_c = 1'b0;
      chk("tdm_lvl", c_lvl, 1);
      en_c = 1'b1;
      wait_rises(2, 1 + 5);
      en_c = 1'b0;
      wait_idle(2);
      cmp_stream(2, "tdm");
      if (cap_c.size() > 128) begin
         chk("tdm_lrc_b62", 32'(cap_c[63][0]), 0);
         chk("tdm_lrc_b63", 32'(cap_c[64][0]), 1);
         chk("tdm_lrc_b126", 32'(cap_c[127][0]), 1);
         chk("tdm_lrc_b127", 32'(cap_c[128][0]), 0);
         for (int p = 0; p < 32; p++)
            chk($sformatf("tdm_slot2_p%0d", p), 32'(cap_c[65 + p][1]), 32'(p < 24));
      end
      chk("tdm_end", {c_bclk, c_dat, c_lvl, c_unr}, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
